// File: rtl/m_mem_stage.sv
// ---------------------------------------------------------------------------
// m_mem_stage
//   Memory stage of the five-stage MIPS pipeline. Decodes load/store opcodes
//   from the instruction in M, owns the byte-enabled data memory, produces
//   sign/zero-extended load data and registers the M->W pipeline register.
//
// Ports
//   clk            clock; all state updates on the rising edge
//   reset          synchronous, active-high; clears W_* and the whole memory
//   M_PC           PC of the instruction in M
//   M_instr        instruction in M (opcode = M_instr[31:26])
//   M_GRF_rt       forwarded rt value, used as store data
//   M_CalcResult   ALU result, used as the effective address
//   M_branch       branch-taken flag carried to W
//   dm_be          byte enables of this cycle's store (0 when no store)
//   dm_addr        word-aligned byte address of the access
//   dm_wdata       merged word written this cycle (old bytes in idle lanes)
//   addr_err       current load/store is misaligned
//   W_PC, W_instr, W_CalcResult, W_DMResult, W_branch   M->W register
// ---------------------------------------------------------------------------
module m_mem_stage #(
    parameter int DM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_instr,
    input  logic [31:0] M_GRF_rt,
    input  logic [31:0] M_CalcResult,
    input  logic        M_branch,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        addr_err,
    output logic [31:0] W_PC,
    output logic [31:0] W_instr,
    output logic [31:0] W_CalcResult,
    output logic [31:0] W_DMResult,
    output logic        W_branch
);

    localparam int AW = $clog2(DM_WORDS);

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    logic [31:0]   mem [DM_WORDS];

    logic [5:0]    opcode;
    logic [1:0]    off;
    logic [AW-1:0] index;
    logic [31:0]   cur_word;

    logic is_load, is_store, word_op, half_op, byte_op, load_signed;
    logic misaligned, store_en;
    logic [31:0] rep_data;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] load_data;

    assign opcode   = M_instr[31:26];
    assign off      = M_CalcResult[1:0];
    // Upper address bits are ignored, so accesses wrap around the memory.
    assign index    = M_CalcResult[AW+1:2];
    assign cur_word = mem[index];
    assign dm_addr  = {M_CalcResult[31:2], 2'b00};

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        word_op     = 1'b0;
        half_op     = 1'b0;
        byte_op     = 1'b0;
        load_signed = 1'b0;
        case (opcode)
            OP_LW:  begin is_load  = 1'b1; word_op = 1'b1; end
            OP_LH:  begin is_load  = 1'b1; half_op = 1'b1; load_signed = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; half_op = 1'b1; end
            OP_LB:  begin is_load  = 1'b1; byte_op = 1'b1; load_signed = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; byte_op = 1'b1; end
            OP_SW:  begin is_store = 1'b1; word_op = 1'b1; end
            OP_SH:  begin is_store = 1'b1; half_op = 1'b1; end
            OP_SB:  begin is_store = 1'b1; byte_op = 1'b1; end
            default: ;
        endcase
    end

    assign misaligned = (word_op && (off != 2'b00)) || (half_op && off[0]);
    assign addr_err   = (is_load || is_store) && misaligned;
    assign store_en   = is_store && !misaligned;

    // Store lanes and lane-replicated store data.
    always_comb begin
        dm_be    = 4'b0000;
        rep_data = M_GRF_rt;
        if (store_en) begin
            if (word_op) begin
                dm_be = 4'b1111;
            end else if (half_op) begin
                dm_be    = off[1] ? 4'b1100 : 4'b0011;
                rep_data = {2{M_GRF_rt[15:0]}};
            end else begin
                dm_be    = 4'b0001 << off;
                rep_data = {4{M_GRF_rt[7:0]}};
            end
        end
    end

    // Merge new bytes into the current word so dm_wdata is the full word
    // the memory will hold after this edge.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            dm_wdata[8*b +: 8] = dm_be[b] ? rep_data[8*b +: 8] : cur_word[8*b +: 8];
        end
    end

    assign half_sel = off[1] ? cur_word[31:16] : cur_word[15:0];
    assign byte_sel = cur_word[8*off +: 8];

    always_comb begin
        load_data = 32'h0;
        if (is_load && !misaligned) begin
            if (word_op)
                load_data = cur_word;
            else if (half_op)
                load_data = {{16{load_signed & half_sel[15]}}, half_sel};
            else
                load_data = {{24{load_signed & byte_sel[7]}}, byte_sel};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the memory is cleared on reset because software relies on a zeroed
    // data segment; reset also wins over a concurrent store.
    always_ff @(posedge clk) begin
        if (reset) begin
            W_PC         <= 32'h0;
            W_instr      <= 32'h0;
            W_CalcResult <= 32'h0;
            W_DMResult   <= 32'h0;
            W_branch     <= 1'b0;
            for (int i = 0; i < DM_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            W_PC         <= M_PC;
            W_instr      <= M_instr;
            W_CalcResult <= M_CalcResult;
            W_DMResult   <= load_data;
            W_branch     <= M_branch;
            for (int b = 0; b < 4; b++) begin
                if (dm_be[b])
                    mem[index][8*b +: 8] <= dm_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/m_mem_stage.md
# m_mem_stage

Memory-stage block of the five-stage MIPS pipeline: consumes the E→M pipeline register outputs (M_PC, M_instr, M_GRF_rt, M_CalcResult, M_branch) and owns the data memory. It decodes load/store opcodes, performs byte/half/word stores with byte enables, returns sign/zero-extended load data, and registers everything the W stage needs into the M→W pipeline register. It also exposes the per-cycle store strobe for the trace monitor.

## Interface
- DM_WORDS, 4096, data memory depth in 32-bit words; power of two; byte address space 0 .. 4*DM_WORDS-1.
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clock clk.
- M_PC  input  32  PC of instruction in M.
- M_instr  input  32  instruction in M; opcode = M_instr[31:26].
- M_GRF_rt  input  32  forwarded rt value (store data).
- M_CalcResult  input  32  ALU result; effective address for loads/stores.
- M_branch  input  1  branch-taken flag carried to W.
- dm_be  output  4  byte enables of the store this cycle (0 when no store).
- dm_addr  output  32  word-aligned byte address of access ({M_CalcResult[31:2],2'b00}).
- dm_wdata  output  32  merged word written this cycle (old bytes in disabled lanes).
- addr_err  output  1  combinational: current load/store misaligned.
- W_PC, W_instr, W_CalcResult, W_DMResult  output  32 each  M→W register.
- W_branch  output  1  M→W register.

## Operation
- Decode: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2B, sh 0x29, sb 0x28; any other opcode is neither load nor store.
- Word index = M_CalcResult[log2(DM_WORDS)+1:2]; upper address bits ignored (wrap-around). Byte offset off = M_CalcResult[1:0], little-endian (off 0 = bits 7:0).
- Alignment: word ops need off==0; half ops need off[0]==0; byte ops always aligned. addr_err=1 only for a misaligned load/store.
- Store byte enables: sw → 4'b1111; sh → 4'b0011 (off 0) or 4'b1100 (off 2); sb → 4'b0001<<off. Store data lane-replicated: sh uses {2{rt[15:0]}}, sb uses {4{rt[7:0]}}. Misaligned store → dm_be=0, memory unchanged.
- dm_wdata = per-byte mux of replicated rt (enabled lanes) and current memory word (disabled lanes); valid in all cycles, meaningful only when dm_be≠0.
- Read: current memory word is read combinationally at the index. lw → word; lh/lhu → half at off[1] selected, sign/zero-extended; lb/lbu → byte at off, sign/zero-extended. Non-load or misaligned load → W_DMResult input 0.
- Memory write: on posedge, each lane with dm_be bit set takes dm_wdata lane.
- M→W register: on posedge, W_PC←M_PC, W_instr←M_instr, W_CalcResult←M_CalcResult, W_DMResult←load data, W_branch←M_branch. No stall/flush inputs; the stage advances every cycle.

## Timing
- Reset (synchronous): all W_* outputs 0; every memory word cleared to 0; reset has priority over a store in the same cycle (store discarded). dm_be/dm_addr/dm_wdata/addr_err are combinational and follow inputs even during reset.
- Load latency: address in M at cycle n → data on W_DMResult after posedge ending cycle n.
- Store visibility: store in cycle n is written at the posedge ending n; a load to the same word in cycle n+1 returns the new data (no bypass needed). A load in the same cycle as a store cannot occur (one instruction per stage).
- Reset deasserted mid-stream: first posedge after deassert captures M inputs normally.

## Test plan
- Reset, then sw rt=0x12345678 @0x10, next cycle lw @0x10 → W_DMResult=0x12345678 one cycle later; dm_be=4'b1111 in store cycle.
- Over word 0x12345678 @0x10: sb rt=0xAB @0x13 → dm_be=4'b1000, dm_wdata=0xAB345678; lw @0x10 → 0xAB345678; lb @0x13 → 0xFFFFFFAB; lbu @0x13 → 0x000000AB.
- sh rt=0x8001 @0x22 → dm_be=4'b1100; lh @0x22 → 0xFFFF8001; lhu @0x22 → 0x00008001; lh @0x20 → 0x00000000.
- Misaligned sw @0x41 and sh @0x43 → addr_err=1, dm_be=0, memory word @0x40 unchanged (lw returns prior value); misaligned lw → W_DMResult=0.
- Wrap: sw 0xCAFEF00D @0x4000 (DM_WORDS=4096) → lw @0x0 returns 0xCAFEF00D.
- sw asserted in same cycle as reset → after reset lw @that address returns 0; all W_* read 0 after reset edge; non-memory instr (addu) passes W_PC/W_instr/W_CalcResult/W_branch through with W_DMResult=0.
